// File: rtl/fifo_arb_pkg.sv
// Shared types and widths for the fifo write-port arbiter.
package fifo_arb_pkg;

  localparam int unsigned BCNT_W = 8;
  localparam int unsigned STAT_W = 32;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_HOLD = 1'b1
  } arb_state_t;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational rotate-priority finder: first set bit of req at or after start, wrapping.
module rr_pick #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] start,
  output logic                 found,
  output logic [$clog2(N)-1:0] idx
);

  localparam int unsigned IW = $clog2(N);

  logic [IW-1:0] cand;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = IW'((32'(start) + k) % N);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Burst-locked round-robin arbiter driving one fifo write port from NUM_REQ producers.
// Optional per-requester grant counters are enabled with `define FIFO_ARB_STATS_EN.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned WIDTH   = 64,
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned BURST   = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic                       fifo_full,
  output logic                       w_valid,
  output logic [WIDTH-1:0]           data_in,
  output logic [$clog2(NUM_REQ)-1:0] gnt_id
`ifdef FIFO_ARB_STATS_EN
  ,
  input  logic [$clog2(NUM_REQ)-1:0] stat_sel,
  input  logic                       stat_clr,
  output logic [STAT_W-1:0]          stat_count
`endif
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  arb_state_t        state_q;
  logic [IDX_W-1:0]  own_q;
  logic [BCNT_W-1:0] bcnt_q;

  logic [IDX_W-1:0]  start;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_found;
  logic              own_valid;
  logic              keep;
  logic              sel_vld;
  logic [IDX_W-1:0]  sel;
  logic              xfer;

  // Search begins just after the current owner so the owner is considered last.
  assign start = (own_q == IDX_W'(NUM_REQ - 1)) ? '0 : own_q + IDX_W'(1);

  rr_pick #(.N(NUM_REQ)) u_rr_pick (
    .req   (req_valid),
    .start (start),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    own_valid = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (own_q == IDX_W'(i)) own_valid = req_valid[i];
    end
    keep    = (state_q == ARB_HOLD) && own_valid && (bcnt_q < BCNT_W'(BURST));
    sel_vld = keep || pick_found;
    sel     = keep ? own_q : pick_idx;
    xfer    = rst_n && sel_vld && !fifo_full;
  end

  // Zero-latency grant; everything forced low while reset is asserted.
  always_comb begin
    req_ready = '0;
    w_valid   = 1'b0;
    data_in   = '0;
    gnt_id    = '0;
    if (rst_n) begin
      gnt_id = own_q;
      if (xfer) begin
        w_valid = 1'b1;
        gnt_id  = sel;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
          if (sel == IDX_W'(i)) begin
            req_ready[i] = 1'b1;
            data_in      = req_data[i*WIDTH +: WIDTH];
          end
        end
      end
    end
  end

  // A full fifo freezes state, owner and burst credit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      own_q   <= IDX_W'(NUM_REQ - 1);
      bcnt_q  <= '0;
    end else if (!fifo_full) begin
      if (sel_vld) begin
        state_q <= ARB_HOLD;
        if (keep) begin
          bcnt_q <= bcnt_q + BCNT_W'(1);
        end else begin
          own_q  <= sel;
          bcnt_q <= BCNT_W'(1);
        end
      end else begin
        state_q <= ARB_IDLE;
      end
    end
  end

`ifdef FIFO_ARB_STATS_EN
  logic [STAT_W-1:0] stat_q [NUM_REQ];

  // Saturating grant counters; clear wins over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) stat_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (stat_clr) begin
          stat_q[i] <= '0;
        end else if (req_ready[i] && (stat_q[i] != '1)) begin
          stat_q[i] <= stat_q[i] + STAT_W'(1);
        end
      end
    end
  end

  always_comb begin
    stat_count = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (rst_n && stat_sel == IDX_W'(i)) stat_count = stat_q[i];
    end
  end
`else
  // Statistics counters are not built; arbitration is unchanged.
`endif

endmodule
